// File: rtl/i2c_readback_tx.sv
// i2c_readback_tx
// Read-direction counterpart of the I2C command/parameter register decoder.
// On rd_req it snapshots the parameter addressed by rd_cmd and streams it to
// the I2C slave byte transmitter as: command echo, value MSB, value LSB.
// An unknown code is echoed as 8'hEE with a zero value.
//
// Optional build macro: I2C_RB_CHECKSUM_EN
//   Appends a fourth byte, echo ^ value[15:8] ^ value[7:0].
//
// Parameters:
//   TIMEOUT_CYC - stalled cycles (tx_valid && !tx_ready) before the frame is
//                 aborted; 0 disables the timeout
//   TO_W        - timeout counter width
//
// Ports:
//   clk, rst           - clock, asynchronous active-low reset
//   rd_req, rd_cmd     - one-cycle read strobe and the code to read back
//   abort              - master STOP/NACK, ends the current frame
//   enable_trigger ... pwm_bus - live parameter register outputs
//   tx_byte, tx_valid, tx_ready - valid/ready byte stream to the transmitter
//   busy               - frame in progress
//   done               - one-cycle pulse, frame completed normally
//   err_pulse          - one-cycle pulse, request dropped / abort / timeout
module i2c_readback_tx #(
  parameter int TIMEOUT_CYC = 0,
  parameter int TO_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic [7:0]  rd_cmd,
  input  logic        abort,
  input  logic [5:0]  enable_trigger,
  input  logic [5:0]  enable_pwm,
  input  logic        multi_pulse,
  input  logic        enable_charging,
  input  logic [15:0] frequency,
  input  logic [95:0] pw_bus,
  input  logic [95:0] pd_bus,
  input  logic [95:0] pwm_bus,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic        err_pulse
);

`ifdef I2C_RB_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, S_CMD, S_HI, S_LO, S_CHK} state_t;
`else
  typedef enum logic [1:0] {IDLE, S_CMD, S_HI, S_LO} state_t;
`endif

  // Stall count at which the timeout fires: the TIMEOUT_CYC-th stalled cycle.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t           state_reg, state_next;
  logic [7:0]       echo_reg, echo_next;
  logic [15:0]      value_reg, value_next;
  logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;

  logic [7:0]       lkp_echo;
  logic [15:0]      lkp_value;
  logic [2:0]       ch;
  logic             chan_ok;
  logic             handshake, stall, timeout;

  // Per-channel views of the buses, padded to 8 entries so a 3-bit channel
  // index never selects outside the array.
  logic [15:0] pw_ch  [8];
  logic [15:0] pd_ch  [8];
  logic [15:0] pwm_ch [8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_ch
      if (gi < 6) begin : g_real
        assign pw_ch[gi]  = pw_bus[16*gi +: 16];
        assign pd_ch[gi]  = pd_bus[16*gi +: 16];
        assign pwm_ch[gi] = pwm_bus[16*gi +: 16];
      end else begin : g_pad
        assign pw_ch[gi]  = '0;
        assign pd_ch[gi]  = '0;
        assign pwm_ch[gi] = '0;
      end
    end
  endgenerate

  // Code -> {echo, value} lookup against the live parameter values.
  always_comb begin
    lkp_echo  = rd_cmd;
    lkp_value = '0;
    ch        = 3'(rd_cmd[3:0] - 4'd1);
    chan_ok   = (rd_cmd[3:0] >= 4'd1) && (rd_cmd[3:0] <= 4'd6);
    if (rd_cmd == 8'hA0)
      lkp_value = {2'b00, enable_trigger, 2'b00, enable_pwm};
    else if (rd_cmd == 8'hA1)
      lkp_value = enable_charging ? 16'd872 : 16'd278;
    else if (rd_cmd == 8'hA2)
      lkp_value = multi_pulse ? 16'd1292 : 16'd2921;
    else if (rd_cmd == 8'hB2)
      lkp_value = frequency;
    else if (rd_cmd[7:4] == 4'hC && chan_ok)
      lkp_value = pw_ch[ch];
    else if (rd_cmd[7:4] == 4'hD && chan_ok)
      lkp_value = pd_ch[ch];
    else if (rd_cmd[7:4] == 4'hE && chan_ok)
      lkp_value = pwm_ch[ch];
    else
      lkp_echo = 8'hEE;
  end

  assign tx_valid  = (state_reg != IDLE);
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign err_pulse = err_reg;

  assign handshake = tx_valid && tx_ready;
  assign stall     = tx_valid && !tx_ready;
  assign timeout   = (TIMEOUT_CYC != 0) && stall && (to_cnt_reg == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      echo_reg   <= 8'h00;
      value_reg  <= 16'h0000;
      to_cnt_reg <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      echo_reg   <= echo_next;
      value_reg  <= value_next;
      to_cnt_reg <= to_cnt_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    echo_next  = echo_reg;
    value_next = value_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    if (state_reg == IDLE) begin
      if (rd_req) begin
        echo_next  = lkp_echo;
        value_next = lkp_value;
        state_next = S_CMD;
      end
    end else begin
      if (rd_req)
        err_next = 1'b1;
      // Abort and timeout win over a handshake in the same cycle.
      if (abort || timeout) begin
        state_next = IDLE;
        err_next   = 1'b1;
      end else if (handshake) begin
        case (state_reg)
          S_CMD:   state_next = S_HI;
          S_HI:    state_next = S_LO;
`ifdef I2C_RB_CHECKSUM_EN
          S_LO:    state_next = S_CHK;
          S_CHK: begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
`else
          S_LO: begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
`endif
          default: state_next = IDLE;
        endcase
      end
    end
    // The stall counter restarts whenever a byte moves or the state changes.
    to_cnt_next = to_cnt_reg;
    if (state_next != state_reg || handshake)
      to_cnt_next = '0;
    else if (stall)
      to_cnt_next = to_cnt_reg + TO_W'(1);
  end

  always_comb begin
    tx_byte = 8'h00;
    case (state_reg)
      S_CMD:   tx_byte = echo_reg;
      S_HI:    tx_byte = value_reg[15:8];
      S_LO:    tx_byte = value_reg[7:0];
`ifdef I2C_RB_CHECKSUM_EN
      S_CHK:   tx_byte = echo_reg ^ value_reg[15:8] ^ value_reg[7:0];
`endif
      default: tx_byte = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_i2c_readback_tx.sv
// Directed bench for i2c_readback_tx: a default instance (no timeout) and a
// second instance with TIMEOUT_CYC=8 share all inputs.
module tb_i2c_readback_tx;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_req = 1'b0;
  logic [7:0]  rd_cmd = 8'h00;
  logic        abort = 1'b0;
  logic [5:0]  enable_trigger = '0;
  logic [5:0]  enable_pwm = '0;
  logic        multi_pulse = 1'b0;
  logic        enable_charging = 1'b0;
  logic [15:0] frequency = '0;
  logic [95:0] pw_bus = '0;
  logic [95:0] pd_bus = '0;
  logic [95:0] pwm_bus = '0;
  logic        tx_ready = 1'b0;

  logic [7:0]  tx_byte, to_tx_byte;
  logic        tx_valid, busy, done, err_pulse;
  logic        to_tx_valid, to_busy, to_done, to_err_pulse;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  i2c_readback_tx dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_cmd(rd_cmd), .abort(abort),
    .enable_trigger(enable_trigger), .enable_pwm(enable_pwm),
    .multi_pulse(multi_pulse), .enable_charging(enable_charging),
    .frequency(frequency), .pw_bus(pw_bus), .pd_bus(pd_bus), .pwm_bus(pwm_bus),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .err_pulse(err_pulse)
  );

  i2c_readback_tx #(.TIMEOUT_CYC(8), .TO_W(16)) dut_to (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_cmd(rd_cmd), .abort(abort),
    .enable_trigger(enable_trigger), .enable_pwm(enable_pwm),
    .multi_pulse(multi_pulse), .enable_charging(enable_charging),
    .frequency(frequency), .pw_bus(pw_bus), .pd_bus(pd_bus), .pwm_bus(pwm_bus),
    .tx_byte(to_tx_byte), .tx_valid(to_tx_valid), .tx_ready(tx_ready),
    .busy(to_busy), .done(to_done), .err_pulse(to_err_pulse)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [7:0] cmd);
    rd_cmd = cmd;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    $display("req cmd=%h", cmd);
  endtask

  // Frame with tx_ready stalled nstall cycles before each byte is accepted.
  task automatic frame(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input int nstall);
    logic [7:0] exp_b [4];
    int nb;
    exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2; exp_b[3] = b0 ^ b1 ^ b2;
`ifdef I2C_RB_CHECKSUM_EN
    nb = 4;
`else
    nb = 3;
`endif
    for (int i = 0; i < nb; i++) begin
      tx_ready = 1'b0;
      for (int s = 0; s < nstall; s++) begin
        chk({tag, "_stall_byte"}, {8'h00, tx_byte}, {8'h00, exp_b[i]});
        tick();
      end
      tx_ready = 1'b1;
      chk({tag, "_valid"}, {15'd0, tx_valid}, 16'd1);
      chk({tag, "_byte"}, {8'h00, tx_byte}, {8'h00, exp_b[i]});
      $display("%s byte%0d=%h", tag, i, tx_byte);
      tick();
    end
    chk({tag, "_done"}, {15'd0, done}, 16'd1);
    chk({tag, "_idle_valid"}, {15'd0, tx_valid}, 16'd0);
    chk({tag, "_idle_busy"}, {15'd0, busy}, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    chk("rst_byte", {8'h00, tx_byte}, 16'h0000);
    chk("rst_valid", {15'd0, tx_valid}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_err", {15'd0, err_pulse}, 16'd0);
    tick();
    rst = 1'b1;
    tick();

    // 1: frequency readback, then back-to-back request in the done cycle
    frequency = 16'h1234;
    tx_ready = 1'b1;
    send_req(8'hB2);
    chk("t1_busy", {15'd0, busy}, 16'd1);
    frame("t1", 8'hB2, 8'h12, 8'h34, 0);

    // 2: enables word, then mode flag
    enable_trigger = 6'h2A;
    enable_pwm = 6'h15;
    send_req(8'hA0);
    frame("t2a", 8'hA0, 8'h2A, 8'h15, 0);
    chk("t2a_err", {15'd0, err_pulse}, 16'd0);
    multi_pulse = 1'b1;
    send_req(8'hA2);
    frame("t2b", 8'hA2, 8'h05, 8'h0C, 0);
    multi_pulse = 1'b0;
    send_req(8'hA2);
    frame("t2c", 8'hA2, 8'h0B, 8'h69, 0);

    // 3: stalled frame, bus changed after the snapshot
    pd_bus = '0;
    pd_bus[48 +: 16] = 16'hBEEF;
    tx_ready = 1'b0;
    send_req(8'hD4);
    pd_bus[48 +: 16] = 16'h1111;
    frame("t3", 8'hD4, 8'hBE, 8'hEF, 5);

    // 4: unknown code, with an ignored request mid-frame
    tx_ready = 1'b1;
    send_req(8'h7F);
    chk("t4_b0", {8'h00, tx_byte}, 16'h00EE);
    rd_cmd = 8'hB2;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("t4_err", {15'd0, err_pulse}, 16'd1);
    chk("t4_b1", {8'h00, tx_byte}, 16'h0000);
    tick();
    chk("t4_err_once", {15'd0, err_pulse}, 16'd0);
    chk("t4_b2", {8'h00, tx_byte}, 16'h0000);
    tick();
`ifdef I2C_RB_CHECKSUM_EN
    chk("t4_chk", {8'h00, tx_byte}, 16'h00EE);
    tick();
`endif
    chk("t4_done", {15'd0, done}, 16'd1);
    chk("t4_valid", {15'd0, tx_valid}, 16'd0);
    $display("t4 unknown-code frame complete");

    // 5: abort in IDLE is ignored; abort in S_HI wins over the handshake
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_idle_abort_err", {15'd0, err_pulse}, 16'd0);
    enable_charging = 1'b1;
    send_req(8'hA1);
    chk("t5_b0", {8'h00, tx_byte}, 16'h00A1);
    tick();
    chk("t5_b1", {8'h00, tx_byte}, 16'h0003);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_valid", {15'd0, tx_valid}, 16'd0);
    chk("t5_busy", {15'd0, busy}, 16'd0);
    chk("t5_err", {15'd0, err_pulse}, 16'd1);
    chk("t5_nodone", {15'd0, done}, 16'd0);
    $display("t5 abort handled");
    pwm_bus[80 +: 16] = 16'h5AA5;
    send_req(8'hE6);
    frame("t5_e6", 8'hE6, 8'h5A, 8'hA5, 0);
    pw_bus[0 +: 16] = 16'h0102;
    send_req(8'hC1);
    frame("t5_c1", 8'hC1, 8'h01, 8'h02, 0);
    send_req(8'hC7);
    frame("t5_c7", 8'hEE, 8'h00, 8'h00, 0);

    // 6: timeout on the TIMEOUT_CYC=8 instance, then async reset mid-frame
    tx_ready = 1'b0;
    send_req(8'hB2);
    for (int i = 1; i <= 8; i++) begin
      chk("t6_to_valid_stalled", {15'd0, to_tx_valid}, 16'd1);
      chk("t6_to_err_quiet", {15'd0, to_err_pulse}, 16'd0);
      tick();
    end
    chk("t6_to_valid_drop", {15'd0, to_tx_valid}, 16'd0);
    chk("t6_to_err", {15'd0, to_err_pulse}, 16'd1);
    chk("t6_to_nodone", {15'd0, to_done}, 16'd0);
    chk("t6_nto_valid", {15'd0, tx_valid}, 16'd1);
    chk("t6_nto_byte", {8'h00, tx_byte}, 16'h00B2);
    $display("t6 timeout after 8 stalled cycles");
    rst = 1'b0;
    #2;
    chk("t6_rst_valid", {15'd0, tx_valid}, 16'd0);
    chk("t6_rst_busy", {15'd0, busy}, 16'd0);
    chk("t6_rst_byte", {8'h00, tx_byte}, 16'h0000);
    chk("t6_rst_done", {15'd0, done}, 16'd0);
    chk("t6_rst_err", {15'd0, err_pulse}, 16'd0);
    $display("t6 async reset mid-frame");
    tick();
    rst = 1'b1;
    tick();
    chk("t6_post_rst_valid", {15'd0, tx_valid}, 16'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/i2c_readback_tx.md
Name: i2c_readback_tx

Overview:
- Read-direction counterpart of the I2C command/parameter register decoder.
- On a read request from the I2C slave front-end, snapshots the addressed parameter (trigger/PWM enables, mode flags, frequency, pulse width/delay, PWM data) and serialises it as a framed byte stream: command echo, data MSB, data LSB.
- Sits between the parameter register outputs and the I2C slave's byte transmitter, which consumes bytes over a valid/ready handshake.

Parameters:
TIMEOUT_CYC, 0, cycles tx_valid may wait for tx_ready before aborting; 0 disables timeout
TO_W, 16, timeout counter width

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-low
rd_req  input  1  one-cycle read request strobe
rd_cmd  input  8  command code to read back, valid with rd_req
abort  input  1  master STOP/NACK; terminates the current frame
enable_trigger  input  6  current trigger enables
enable_pwm  input  6  current PWM enables
multi_pulse  input  1  1 = repeat mode
enable_charging  input  1  charging enable
frequency  input  16  frequency word
pw_bus  input  96  pulse widths; channel i at [16*i+:16]
pd_bus  input  96  pulse delays; channel i at [16*i+:16]
pwm_bus  input  96  PWM data; channel i at [16*i+:16]
tx_byte  output  8  byte to transmit
tx_valid  output  1  tx_byte valid
tx_ready  input  1  transmitter accepts tx_byte this cycle
busy  output  1  frame in progress
done  output  1  one-cycle pulse: frame completed normally
err_pulse  output  1  one-cycle pulse: request dropped while busy, abort, or timeout

Behaviour:
- Reset values: tx_byte 0x00, tx_valid 0, busy 0, done 0, err_pulse 0; FSM in IDLE; timeout counter 0.
- FSM states: IDLE, S_CMD, S_HI, S_LO (S_CHK with the optional feature).
- IDLE: on rd_req, latch {code, 16-bit value} in the same cycle and go to S_CMD. tx_valid=1 and busy=1 from the next cycle (latency 1).
- Value map:
  - A0: {2'b0, enable_trigger, 2'b0, enable_pwm}
  - A1: enable_charging ? 16'd872 : 16'd278
  - A2: multi_pulse ? 16'd1292 : 16'd2921
  - B2: frequency
  - C1..C6: pw_bus channel 0..5
  - D1..D6: pd_bus channel 0..5
  - E1..E6: pwm_bus channel 0..5
- Unknown code: the echo byte is 8'hEE and the value is 16'h0000; the frame is otherwise normal.
- Byte order: S_CMD sends the echo byte (code or EE), S_HI sends value[15:8], S_LO sends value[7:0].
- Advance rule: the state advances only on a cycle where tx_valid && tx_ready. The next byte appears the following cycle with tx_valid held high, so back-to-back transfer is allowed.
- tx_byte is stable while tx_valid && !tx_ready.
- The snapshot is immune to parameter changes mid-frame.
- Completion: handshake in the last byte state leads, next cycle, to IDLE with done=1, tx_valid=0, busy=0. A rd_req in that same cycle is accepted.
- rd_req while busy: ignored, err_pulse=1 next cycle, the frame continues unaffected.
- abort in any non-IDLE state:
  - Next cycle: IDLE, tx_valid=0, err_pulse=1, no done.
  - abort has priority over a simultaneous handshake.
  - abort in IDLE has no effect.
- Timeout:
  - The counter increments each cycle with tx_valid && !tx_ready and clears on a handshake or state change.
  - Reaching TIMEOUT_CYC (when non-zero) acts as abort.
- Reset mid-frame: immediate return to reset values, no partial byte.

Optional Feature:
I2C_RB_CHECKSUM_EN:
- Defined: adds state S_CHK after S_LO, sending echo ^ value[15:8] ^ value[7:0]. done follows the S_CHK handshake. The frame is 4 bytes.
- Undefined: the frame is 3 bytes, S_CHK is absent, and done follows the S_LO handshake.

Test Plan:
1. Reset, then rd_req with rd_cmd=B2, frequency=0x1234, tx_ready=1 → bytes B2, 12, 34 on consecutive cycles starting 1 cycle after rd_req; done on the cycle after 34; checksum build appends B2^12^34=0x94.
2. enable_trigger=6'h2A, enable_pwm=6'h15, rd_cmd=A0 → value 0x2A15, bytes A0, 2A, 15; then multi_pulse=1, rd_cmd=A2 → A2, 05, 0C.
3. rd_cmd=D4, pd_bus channel 3=0xBEEF; tx_ready low 5 cycles per byte; change pd_bus mid-frame → D4, BE, EF held stable during stalls, snapshot value unchanged.
4. rd_cmd=7F → EE, 00, 00, done asserted; second rd_req during the frame → err_pulse once, frame completes unaltered.
5. abort asserted during S_HI together with tx_ready=1 → next cycle tx_valid=0, busy=0, err_pulse=1, no done; new rd_req (E6) then yields a full frame.
6. TIMEOUT_CYC=8, tx_ready held 0 → err_pulse and tx_valid=0 after 8 stalled cycles; rst pulsed mid-frame in a separate run → all outputs return to reset values immediately.
